imm_extend_stage: RTL and testbench
===================================

# imm_extend_stage

Registered immediate-generation stage for the 16-bit pipelined CPU decode path. It extracts the immediate field selected by the decoder, then zero- or sign-extends it to a parametrised datapath width. It also supports a prefix word that supplies the upper 11 bits of the following instruction's immediate, which gives full 16-bit immediates. The block sits between the decoder and the ID/EX register, with one-cycle latency and stall/flush control.

## Interface
Parameters:
- DATA_W, 16, output immediate width; legal values are ≥ 16.
- INSTR_W, 16, instruction width; fixed at 16 in this generation.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  the instruction and select inputs are valid this cycle.
- instruction  input  INSTR_W  current instruction word.
- im_src_select  input  4  bit 3 = 1 sign-extend / 0 zero-extend; bits [2:0] = field code.
- prefix_en  input  1  the current instruction is a prefix word (decoder-qualified).
- stall  input  1  hold all state and outputs.
- flush  input  1  kill the in-flight result and any pending prefix.
- out_valid  output  1  imm_out is valid.
- imm_out  output  DATA_W  extended immediate.
- imm_extended  output  1  imm_out was composed with a prefix.
- prefix_pending  output  1  a prefix has been captured but not yet consumed.
- prefix_error  output  1  one-cycle pulse for a prefix-on-prefix or a reserved select code.

## Operation
Field codes (bits [2:0]):
- 000: instruction[7:0].
- 001: instruction[3:0].
- 010: instruction[4:0].
- 011: instruction[10:0].
- 100: instruction[4:2].
- 101: instruction[4:2], except that a value of 0 encodes 8.
- 110/111: reserved; result is 0 and prefix_error pulses.

Extension rules:
- Extension uses the field's MSB when bit 3 = 1; otherwise it zero-fills.
- Code 101 is always zero-extended, regardless of bit 3.

Prefix state machine, states IDLE and PFX:
- IDLE, in_valid & prefix_en: capture instruction[10:0] into pfx_reg and go to PFX. No out_valid is produced for the prefix word.
- PFX, in_valid & !prefix_en, code 000–011: result is {pfx_reg, instruction[4:0]} (16 bits), extended to DATA_W per bit 3. Set imm_extended = 1 and return to IDLE.
- PFX, code 100/101: the prefix is consumed with no effect, the normal field applies, imm_extended = 0, and the state returns to IDLE.
- PFX, in_valid & prefix_en: the new prefix replaces pfx_reg, prefix_error pulses, and the state stays in PFX.
- Any state, in_valid = 0: no change.

Control precedence: reset > flush > stall > normal.
- flush: out_valid ← 0, imm_extended ← 0, state ← IDLE. imm_out holds its last value.
- stall: every register holds, prefix_error ← 0, and inputs are ignored.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- out_valid ← in_valid & !prefix_en on every unstalled, unflushed edge.
- prefix_pending reflects the state register (PFX = 1), valid the cycle after capture.
- prefix_error is high for exactly one cycle after the offending edge.
- Reset values: out_valid 0, imm_out 0, imm_extended 0, prefix_pending 0, prefix_error 0, state IDLE, pfx_reg 0.
- Reset asserted while in PFX discards the prefix immediately (asynchronously).
- Flush and stall in the same cycle: flush wins.
- A prefix arriving with flush is discarded.

## Structure
- Package imm_pkg holds:
  - select-code localparams (IMM_F8, IMM_F4, IMM_F5, IMM_F11, IMM_F3, IMM_SHAMT);
  - PREFIX_W = 11;
  - the state encoding (ST_IDLE, ST_PFX).
- Sub-module imm_field_extract: purely combinational field select plus extension to DATA_W. It takes instruction, select, a prefix-apply flag and pfx_reg, and outputs the value and a reserved-code flag.
- The top level holds the state machine and the output registers.

## Test plan
- Select 4'b1000, instruction 16'h00F0 → next cycle out_valid = 1, imm_out = 16'hFFF0. With select 4'b0000 → 16'h00F0.
- Select 4'b0101: instruction[4:2] = 000 → imm_out = 8; instruction[4:2] = 011 → imm_out = 3. The same results hold with bit 3 = 1.
- Prefix with instruction[10:0] = 11'h400, then select 4'b1010 with instruction[4:0] = 5'h15, DATA_W = 32:
  - after the prefix word: out_valid = 0, prefix_pending = 1;
  - after the following instruction: imm_out = 32'hFFFF8015, imm_extended = 1, prefix_pending = 0.
- Prefix 11'h123, then flush, then select 4'b0010 with instruction[4:0] = 5'h15 → imm_out = 16'h0015, imm_extended = 0.
- Two prefixes back-to-back → prefix_error pulses for 1 cycle and the second prefix is applied. Stall held 3 cycles mid-sequence → outputs and prefix_pending stay frozen.
- rst_n pulled low asynchronously while in PFX → all outputs 0 immediately. Select 4'b0110 → imm_out = 0, prefix_error pulses.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: field select codes,
// prefix width and the prefix state encoding.
package imm_pkg;

    localparam logic [2:0] IMM_F8    = 3'b000;
    localparam logic [2:0] IMM_F4    = 3'b001;
    localparam logic [2:0] IMM_F5    = 3'b010;
    localparam logic [2:0] IMM_F11   = 3'b011;
    localparam logic [2:0] IMM_F3    = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;

    localparam int PREFIX_W = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PFX  = 1'b1
    } state_t;

    // Codes 000-011 are the ones a pending prefix widens.
    function automatic logic is_prefixable(input logic [2:0] code);
        return !code[2];
    endfunction

endpackage

// File: rtl/imm_field_extract.sv
// Combinational immediate field select, optional prefix composition and
// zero/sign extension to the datapath width.
module imm_field_extract
    import imm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0]  instruction,
    input  logic [3:0]          select,
    input  logic                prefix_apply,
    input  logic [PREFIX_W-1:0] pfx_reg,
    output logic [DATA_W-1:0]   value,
    output logic                reserved
);

    logic        sign;
    logic        wide_sign;
    logic [15:0] raw;
    logic        unused_bits;

    assign sign        = select[3];
    assign unused_bits = ^instruction[INSTR_W-1:PREFIX_W];

    // raw is already extended to 16 bits; wide_sign carries it on to DATA_W.
    always_comb begin
        raw       = 16'd0;
        reserved  = 1'b0;
        wide_sign = 1'b0;
        if (prefix_apply && is_prefixable(select[2:0])) begin
            raw       = {pfx_reg, instruction[4:0]};
            wide_sign = sign & pfx_reg[PREFIX_W-1];
        end else begin
            case (select[2:0])
                IMM_F8:    raw = {{8{sign & instruction[7]}}, instruction[7:0]};
                IMM_F4:    raw = {{12{sign & instruction[3]}}, instruction[3:0]};
                IMM_F5:    raw = {{11{sign & instruction[4]}}, instruction[4:0]};
                IMM_F11:   raw = {{5{sign & instruction[10]}}, instruction[10:0]};
                IMM_F3:    raw = {{13{sign & instruction[4]}}, instruction[4:2]};
                IMM_SHAMT: raw = (instruction[4:2] == 3'd0) ? 16'd8
                                                            : {13'd0, instruction[4:2]};
                default:   reserved = 1'b1;
            endcase
            wide_sign = raw[15];
        end
    end

    assign value = wide_sign ? DATA_W'($signed(raw)) : DATA_W'(raw);

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate stage between decoder and ID/EX: one-cycle latency,
// prefix-word support for full 16-bit immediates, stall and flush control.
module imm_extend_stage
    import imm_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [3:0]         im_src_select,
    input  logic               prefix_en,
    input  logic               stall,
    input  logic               flush,
    output logic               out_valid,
    output logic [DATA_W-1:0]  imm_out,
    output logic               imm_extended,
    output logic               prefix_pending,
    output logic               prefix_error
);

    state_t              state;
    logic [PREFIX_W-1:0] pfx_reg;
    logic                prefix_apply;
    logic [DATA_W-1:0]   field_value;
    logic                field_reserved;

    assign prefix_apply   = (state == ST_PFX) && !prefix_en;
    assign prefix_pending = (state == ST_PFX);

    imm_field_extract #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W)
    ) u_extract (
        .instruction  (instruction),
        .select       (im_src_select),
        .prefix_apply (prefix_apply),
        .pfx_reg      (pfx_reg),
        .value        (field_value),
        .reserved     (field_reserved)
    );

    // imm_out deliberately survives flush; only validity and the prefix are killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pfx_reg      <= '0;
            out_valid    <= 1'b0;
            imm_out      <= '0;
            imm_extended <= 1'b0;
            prefix_error <= 1'b0;
        end else if (flush) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
            imm_extended <= 1'b0;
            prefix_error <= 1'b0;
        end else if (stall) begin
            prefix_error <= 1'b0;
        end else begin
            out_valid    <= in_valid && !prefix_en;
            prefix_error <= 1'b0;
            if (in_valid) begin
                if (prefix_en) begin
                    pfx_reg      <= instruction[PREFIX_W-1:0];
                    state        <= ST_PFX;
                    imm_extended <= 1'b0;
                    prefix_error <= (state == ST_PFX);
                end else begin
                    imm_out      <= field_value;
                    imm_extended <= prefix_apply && is_prefixable(im_src_select[2:0]);
                    prefix_error <= field_reserved;
                    state        <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench for imm_extend_stage at DATA_W = 32: directed vectors push
// expected results, a monitor pops and compares whenever a fresh result appears.
module tb_imm_extend_stage;

    localparam int DATA_W  = 32;
    localparam int INSTR_W = 16;

    typedef struct {
        logic [DATA_W-1:0] imm;
        logic              ext;
        logic              err;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [INSTR_W-1:0] instruction;
    logic [3:0]         im_src_select;
    logic               prefix_en;
    logic               stall;
    logic               flush;
    logic               out_valid;
    logic [DATA_W-1:0]  imm_out;
    logic               imm_extended;
    logic               prefix_pending;
    logic               prefix_error;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    logic adv;
    logic held;

    imm_extend_stage #(
        .DATA_W  (DATA_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .instruction    (instruction),
        .im_src_select  (im_src_select),
        .prefix_en      (prefix_en),
        .stall          (stall),
        .flush          (flush),
        .out_valid      (out_valid),
        .imm_out        (imm_out),
        .imm_extended   (imm_extended),
        .prefix_pending (prefix_pending),
        .prefix_error   (prefix_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    // Decide from the driven inputs whether this edge must produce a new result.
    always @(posedge clk) begin
        adv  = rst_n && !flush && !stall && in_valid && !prefix_en;
        held = rst_n && !flush && stall;
    end

    always @(negedge clk) begin
        exp_t e;
        if (adv) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL scoreboard: output imm_out=%h with no expected entry", imm_out);
            end else begin
                e = sb.pop_front();
                if (out_valid !== 1'b1 || imm_out !== e.imm ||
                    imm_extended !== e.ext || prefix_error !== e.err) begin
                    miscompares++;
                    $display("[TB] FAIL result: got valid=%b imm=%h ext=%b err=%b, want valid=1 imm=%h ext=%b err=%b",
                             out_valid, imm_out, imm_extended, prefix_error, e.imm, e.ext, e.err);
                end
            end
        end else if (!held && out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL spurious_valid: got out_valid=%b, want 0", out_valid);
        end
    end

    task automatic applyStimulus(input logic v, input logic [15:0] ins, input logic [3:0] sel,
                                 input logic pe, input logic st, input logic fl);
        in_valid      = v;
        instruction   = ins;
        im_src_select = sel;
        prefix_en     = pe;
        stall         = st;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic sendOp(input logic [3:0] sel, input logic [15:0] ins,
                          input logic [DATA_W-1:0] imm, input logic ext, input logic err);
        sb.push_back('{imm: imm, ext: ext, err: err});
        applyStimulus(1'b1, ins, sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendPrefix(input logic [15:0] ins);
        applyStimulus(1'b1, ins, 4'b0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        instruction   = '0;
        im_src_select = '0;
        prefix_en     = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        #3;
        checkOutput("reset_out_valid", DATA_W'(out_valid), 0);
        checkOutput("reset_imm_out", imm_out, 0);
        checkOutput("reset_imm_extended", DATA_W'(imm_extended), 0);
        checkOutput("reset_prefix_pending", DATA_W'(prefix_pending), 0);
        checkOutput("reset_prefix_error", DATA_W'(prefix_error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain field selects and extension rules
        sendOp(4'b1000, 16'h00F0, 32'hFFFF_FFF0, 1'b0, 1'b0);
        sendOp(4'b0000, 16'h00F0, 32'h0000_00F0, 1'b0, 1'b0);
        sendOp(4'b0101, 16'h0000, 32'd8, 1'b0, 1'b0);
        sendOp(4'b0101, 16'h000C, 32'd3, 1'b0, 1'b0);
        sendOp(4'b1101, 16'h0000, 32'd8, 1'b0, 1'b0);
        sendOp(4'b1101, 16'h000C, 32'd3, 1'b0, 1'b0);
        sendOp(4'b1101, 16'h001C, 32'd7, 1'b0, 1'b0);
        sendOp(4'b1100, 16'h001C, 32'hFFFF_FFFF, 1'b0, 1'b0);
        sendOp(4'b0100, 16'h001C, 32'd7, 1'b0, 1'b0);
        sendOp(4'b1001, 16'h0008, 32'hFFFF_FFF8, 1'b0, 1'b0);
        sendOp(4'b1010, 16'h0010, 32'hFFFF_FFF0, 1'b0, 1'b0);
        sendOp(4'b1011, 16'h0400, 32'hFFFF_FC00, 1'b0, 1'b0);
        sendOp(4'b0011, 16'h07FF, 32'h0000_07FF, 1'b0, 1'b0);

        // Stall with a valid result: output frozen
        sendOp(4'b1000, 16'h00F0, 32'hFFFF_FFF0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h00AA, 4'b0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h00AA, 4'b0000, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_imm_hold", imm_out, 32'hFFFF_FFF0);
        checkOutput("stall_valid_hold", DATA_W'(out_valid), 1);

        // Prefix composition with sign extension
        sendPrefix(16'h0400);
        checkOutput("pfx_no_valid", DATA_W'(out_valid), 0);
        checkOutput("pfx_pending", DATA_W'(prefix_pending), 1);
        sendOp(4'b1010, 16'h0015, 32'hFFFF_8015, 1'b1, 1'b0);
        checkOutput("pfx_consumed", DATA_W'(prefix_pending), 0);

        // Flush clears validity and imm_extended but keeps imm_out
        applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_ext_clear", DATA_W'(imm_extended), 0);
        checkOutput("flush_imm_hold", imm_out, 32'hFFFF_8015);

        // Prefix killed by flush
        sendPrefix(16'h0123);
        applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_kills_pfx", DATA_W'(prefix_pending), 0);
        sendOp(4'b0010, 16'h0015, 32'h0000_0015, 1'b0, 1'b0);

        // Back-to-back prefixes, stall mid-sequence, second prefix applied
        sendPrefix(16'h0001);
        sendPrefix(16'h07FF);
        checkOutput("pfx_on_pfx_error", DATA_W'(prefix_error), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b1, 1'b0);
            checkOutput("stall_pending_hold", DATA_W'(prefix_pending), 1);
            checkOutput("stall_error_clear", DATA_W'(prefix_error), 0);
        end
        sendOp(4'b0001, 16'h000A, 32'h0000_FFEA, 1'b1, 1'b0);

        // Code 100 consumes the prefix without composing
        sendPrefix(16'h0555);
        sendOp(4'b1100, 16'h0004, 32'd1, 1'b0, 1'b0);
        checkOutput("f3_consumes_pfx", DATA_W'(prefix_pending), 0);

        // Flush with an instruction, flush beating stall, prefix arriving with flush
        applyStimulus(1'b1, 16'h00F0, 4'b1000, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_drops_op_imm", imm_out, 32'd1);
        applyStimulus(1'b1, 16'h0123, 4'b0000, 1'b1, 1'b0, 1'b1);
        checkOutput("pfx_with_flush", DATA_W'(prefix_pending), 0);
        sendPrefix(16'h0123);
        applyStimulus(1'b0, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        checkOutput("flush_beats_stall", DATA_W'(prefix_pending), 0);

        // Reserved codes
        sendOp(4'b0110, 16'hFFFF, 32'd0, 1'b0, 1'b1);
        idle();
        checkOutput("reserved_err_pulse", DATA_W'(prefix_error), 0);
        sendOp(4'b1111, 16'hFFFF, 32'd0, 1'b0, 1'b1);

        // Asynchronous reset while a prefix is pending
        sendOp(4'b0011, 16'h07FF, 32'h0000_07FF, 1'b0, 1'b0);
        sendPrefix(16'h0200);
        checkOutput("pre_reset_pending", DATA_W'(prefix_pending), 1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        prefix_en = 1'b0;
        #1;
        checkOutput("async_rst_pending", DATA_W'(prefix_pending), 0);
        checkOutput("async_rst_imm", imm_out, 0);
        checkOutput("async_rst_valid", DATA_W'(out_valid), 0);
        checkOutput("async_rst_ext", DATA_W'(imm_extended), 0);
        checkOutput("async_rst_err", DATA_W'(prefix_error), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sendOp(4'b0010, 16'h0015, 32'h0000_0015, 1'b0, 1'b0);

        idle();
        idle();
        checkOutput("scoreboard_drained", DATA_W'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
